fa_factorial_seq: RTL and testbench

- Sequencer on the initiator side of the factorial datapath's combinational ALU interface (operands A/B, 3-bit opcode, 32-bit result, equality flag).
- Accepts n on a start pulse and computes n! by issuing SUB and MUL operations to an external ALU instance, one operation per cycle.
- Reports result, done and overflow to the top-level controller.

---
 rtl/fa_factorial_seq_if.sv | 27 ++
 rtl/fa_factorial_seq.sv | 106 ++++++++++
 tb/tb_fa_factorial_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fa_factorial_seq_if.sv
// Signal bundle between the factorial sequencer, its controller and the external combinational ALU.
// The master side is the controller plus the ALU; the slave side is the sequencer.
interface fa_factorial_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_is_zero;

  modport master (
    output start, n, alu_result, alu_is_zero,
    input  busy, done, result, overflow, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, n, alu_result, alu_is_zero,
    output busy, done, result, overflow, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/fa_factorial_seq.sv
// Computes n! by sequencing SUB/MUL operations on an external combinational ALU,
// one operation per cycle, and reports result/done/overflow to the controller.
module fa_factorial_seq #(
  parameter int DATA_W    = 32,
  parameter int OVF_LIMIT = 12
) (
  input  logic               clk,
  input  logic               reset,
  fa_factorial_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CHECK, MUL, DEC, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              ovf_pend_reg, ovf_pend_next;
  logic              overflow_reg, overflow_next;
  logic [DATA_W-1:0] alu_a_c, alu_b_c;
  logic [2:0]        alu_op_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      result_reg   <= '0;
      ovf_pend_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      result_reg   <= result_next;
      ovf_pend_reg <= ovf_pend_next;
      overflow_reg <= overflow_next;
    end
  end

  // ALU operands depend only on state and registers; alu_result is consumed at the cycle's end.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    result_next   = result_reg;
    ovf_pend_next = ovf_pend_reg;
    overflow_next = overflow_reg;
    alu_a_c       = '0;
    alu_b_c       = '0;
    alu_op_c      = OP_ADD;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          cnt_next      = (bus.n == '0) ? DATA_W'(1) : bus.n;
          acc_next      = DATA_W'(1);
          ovf_pend_next = (bus.n > DATA_W'(OVF_LIMIT));
          state_next    = CHECK;
        end
      end
      CHECK: begin
        alu_a_c  = cnt_reg;
        alu_b_c  = DATA_W'(1);
        alu_op_c = OP_SUB;
        if (bus.alu_is_zero) begin
          result_next   = acc_reg;
          overflow_next = ovf_pend_reg;
          state_next    = DONE;
        end else begin
          state_next = MUL;
        end
      end
      MUL: begin
        alu_a_c    = acc_reg;
        alu_b_c    = cnt_reg;
        alu_op_c   = OP_MUL;
        acc_next   = bus.alu_result;
        state_next = DEC;
      end
      DEC: begin
        alu_a_c    = cnt_reg;
        alu_b_c    = DATA_W'(1);
        alu_op_c   = OP_SUB;
        cnt_next   = bus.alu_result;
        state_next = CHECK;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.alu_a    = alu_a_c;
  assign bus.alu_b    = alu_b_c;
  assign bus.alu_op   = alu_op_c;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.result   = result_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_fa_factorial_seq.sv
// Directed bench for fa_factorial_seq with a behavioural combinational ALU and a per-cycle bus monitor.
module tb_fa_factorial_seq;
  logic clk = 1'b0;
  logic reset;

  fa_factorial_seq_if #(.DATA_W(32)) bus ();

  fa_factorial_seq #(.DATA_W(32), .OVF_LIMIT(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND.
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a * bus.alu_b;
      3'b011:  bus.alu_result = (bus.alu_b != 0) ? bus.alu_a / bus.alu_b : 32'd0;
      3'b100:  bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = 32'd0;
    endcase
  end
  assign bus.alu_is_zero = (bus.alu_a == bus.alu_b);

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          done_cnt = 0;
  int          mul_cnt  = 0;
  logic [31:0] tb_acc   = 32'd1;
  logic        op_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: legal opcodes, SUB always by 1, MUL operand A tracks an independent product model.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    op_ok = bus.alu_op inside {3'b000, 3'b001, 3'b010};
    check("op_legal", {31'd0, op_ok}, 32'd1);
    if (bus.alu_op == 3'b001) check("sub_b_one", bus.alu_b, 32'd1);
    if (bus.busy !== 1'b1) begin
      tb_acc = 32'd1;
    end else if (bus.alu_op == 3'b010) begin
      mul_cnt++;
      check("mul_a_acc", bus.alu_a, tb_acc);
      tb_acc = tb_acc * bus.alu_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle right after acceptance (cycle 1); returns the cycle index where done is seen.
  task automatic wait_done(output int cyc);
    bit seen;
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < 400) begin
      if (bus.done === 1'b1) seen = 1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic run(input logic [31:0] nv, input int exp_cyc, input logic [31:0] exp_res,
                     input logic exp_ovf, input bit hold_start);
    int cyc;
    bus.start = 1'b1;
    bus.n     = nv;
    tick();
    if (hold_start) bus.n = nv + 32'd3;
    else bus.start = 1'b0;
    check("busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc);
    check("done_cycle", cyc, exp_cyc);
    check("result", bus.result, exp_res);
    check("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
    $display("run n=%0d: done in cycle %0d, result=%0d, overflow=%0b", nv, cyc, bus.result, bus.overflow);
  endtask

  initial begin
    int m;
    int dc;
    int cyc;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.n     = 32'd0;
    tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // n = 5: done in cycle 14, busy drops after the single done cycle, result held afterwards
    run(32'd5, 14, 32'd120, 1'b0, 1'b0);
    tick();
    check("n5_done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("n5_busy_after", {31'd0, bus.busy}, 32'd0);
    tick();
    check("n5_result_held", bus.result, 32'd120);

    // n = 0 and n = 1 finish without any MUL
    m = mul_cnt;
    run(32'd0, 2, 32'd1, 1'b0, 1'b0);
    tick();
    check("n0_no_mul", mul_cnt, m);
    m = mul_cnt;
    run(32'd1, 2, 32'd1, 1'b0, 1'b0);
    tick();
    check("n1_no_mul", mul_cnt, m);

    // Largest non-overflowing n, then first wrapping n
    run(32'd12, 35, 32'd479001600, 1'b0, 1'b0);
    tick();
    run(32'd13, 38, 32'd1932053504, 1'b1, 1'b0);
    tick();

    // start held high, n changed to 7 mid-run: 4! first, then one idle cycle, then a 7! run
    dc = done_cnt;
    run(32'd4, 11, 32'd24, 1'b0, 1'b1);
    tick();
    check("held_idle_gap_busy", {31'd0, bus.busy}, 32'd0);
    check("held_single_done", done_cnt, dc + 1);
    tick();
    check("held_restart_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done(cyc);
    check("n7_done_cycle", cyc, 20);
    check("n7_result", bus.result, 32'd5040);
    $display("run n=7: done in cycle %0d, result=%0d", cyc, bus.result);
    tick();

    // Asynchronous reset during MUL of an n = 6 run
    bus.start = 1'b1;
    bus.n     = 32'd6;
    tick();
    bus.start = 1'b0;
    tick();
    check("n6_in_mul", {29'd0, bus.alu_op}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_overflow", {31'd0, bus.overflow}, 32'd0);
    check("arst_alu_a", bus.alu_a, 32'd0);
    check("arst_alu_b", bus.alu_b, 32'd0);
    check("arst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    dc = done_cnt;
    tick();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("arst_no_done", done_cnt, dc);
    $display("reset during n=6 run: outputs cleared, no done");
    run(32'd3, 8, 32'd6, 1'b0, 1'b0);
    tick();

    check("total_done_pulses", done_cnt, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
